// File: rtl/sprite_blitter_param.sv
// Sprite copy engine: reads a w x h sprite from SDRAM and writes it into a linear framebuffer
// with colour-key transparency and screen-edge clipping. `BLITTER_HFLIP_EN adds horizontal mirroring.
module sprite_blitter_param #(
  parameter int unsigned ADDR_W   = 25,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_W    = 64,
  parameter int unsigned MAX_H    = 64,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  localparam int unsigned WW = $clog2(MAX_W) + 1,
  localparam int unsigned HW = $clog2(MAX_H) + 1,
  localparam int unsigned PW = $clog2(MAX_W * MAX_H) + 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic [9:0]        dst_x,
  input  logic [9:0]        dst_y,
  input  logic [WW-1:0]     spr_w,
  input  logic [HW-1:0]     spr_h,
  input  logic              key_en,
  input  logic [DATA_W-1:0] key_color,
`ifdef BLITTER_HFLIP_EN
  input  logic              hflip,
`endif
  output logic              busy,
  output logic              done,
  output logic [PW-1:0]     pix_written,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   src_base_q, fb_base_q;
  logic [9:0]          dst_x_q, dst_y_q;
  logic [WW-1:0]       spr_w_q, col_q;
  logic [HW-1:0]       spr_h_q, row_q;
  logic                key_en_q;
  logic [DATA_W-1:0]   key_color_q;
`ifdef BLITTER_HFLIP_EN
  logic                hflip_q;
`endif

  logic [10:0]         x_sum, y_sum;
  logic                clipped, last_col, last_pix;
  logic [WW-1:0]       src_col, col_nxt;
  logic [HW-1:0]       row_nxt;
  logic [ADDR_W-1:0]   rd_addr, wr_addr;

  always_comb begin
    // 11-bit sums so a destination beyond the screen edge can never wrap back on-screen
    x_sum    = {1'b0, dst_x_q} + 11'(col_q);
    y_sum    = {1'b0, dst_y_q} + 11'(row_q);
    clipped  = (x_sum >= 11'(SCREEN_W)) || (y_sum >= 11'(SCREEN_H));
    src_col  = col_q;
`ifdef BLITTER_HFLIP_EN
    if (hflip_q) src_col = spr_w_q - WW'(1) - col_q;
`endif
    last_col = (col_q == spr_w_q - WW'(1));
    last_pix = last_col && (row_q == spr_h_q - HW'(1));
    col_nxt  = last_col ? '0 : col_q + WW'(1);
    row_nxt  = last_col ? row_q + HW'(1) : row_q;
    rd_addr  = src_base_q + ADDR_W'(row_q) * ADDR_W'(spr_w_q) + ADDR_W'(src_col);
    wr_addr  = fb_base_q + ADDR_W'(y_sum) * ADDR_W'(SCREEN_W) + ADDR_W'(x_sum);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      src_base_q  <= '0;
      fb_base_q   <= '0;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      spr_w_q     <= '0;
      spr_h_q     <= '0;
      key_en_q    <= 1'b0;
      key_color_q <= '0;
`ifdef BLITTER_HFLIP_EN
      hflip_q     <= 1'b0;
`endif
      col_q       <= '0;
      row_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pix_written <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            src_base_q  <= src_base;
            fb_base_q   <= fb_base;
            dst_x_q     <= dst_x;
            dst_y_q     <= dst_y;
            spr_w_q     <= spr_w;
            spr_h_q     <= spr_h;
            key_en_q    <= key_en;
            key_color_q <= key_color;
`ifdef BLITTER_HFLIP_EN
            hflip_q     <= hflip;
`endif
            col_q       <= '0;
            row_q       <= '0;
            pix_written <= '0;
            busy        <= 1'b1;
            state_q     <= (spr_w == '0 || spr_h == '0) ? StDone : StRead;
          end
        end
        StRead: begin
          if (!mem_rd) begin
            // First cycle of a pixel: either skip it (clipped) or launch the read
            if (clipped) begin
              col_q   <= col_nxt;
              row_q   <= row_nxt;
              state_q <= last_pix ? StDone : StRead;
            end else begin
              mem_rd   <= 1'b1;
              mem_addr <= rd_addr;
            end
          end else if (mem_ack) begin
            mem_rd <= 1'b0;
            if (key_en_q && mem_rdata == key_color_q) begin
              col_q   <= col_nxt;
              row_q   <= row_nxt;
              state_q <= last_pix ? StDone : StRead;
            end else begin
              mem_wr    <= 1'b1;
              mem_addr  <= wr_addr;
              mem_wdata <= mem_rdata;
              state_q   <= StWrite;
            end
          end
        end
        StWrite: begin
          if (mem_ack) begin
            mem_wr      <= 1'b0;
            pix_written <= pix_written + PW'(1);
            col_q       <= col_nxt;
            row_q       <= row_nxt;
            state_q     <= last_pix ? StDone : StRead;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
